// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell stepped LSB first over
// WIDTH cycles, start/busy/done handshake, registered carry and result.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_s;
  logic fa_c;
  logic last;

  always_comb begin
    fa_s = a_q[0] ^ b_q[0] ^ c_q;
    fa_c = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    last = (cnt_q == CW'(WIDTH - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request just like IDLE, so back-to-back
        // operations need no idle gap.
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          r_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_c;
        r_d   = WIDTH'({fa_s, r_q} >> 1);
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          sum_d   = r_d;
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances checked
// against plain a+b+cin arithmetic and the start/busy/done timing.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [8:0] held = '0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge of the DONE cycle.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input logic [7:0] es,
                      input logic ec, input bit noisy);
    a8 = ta;
    b8 = tb;
    cin8 = tc;
    start8 = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      start8 = noisy ? 1'($urandom % 2) : 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      cin8 = 1'($urandom % 2);
      chk("busy_run", 32'(busy8), 32'd1);
      chk("done_run", 32'(done8), 32'd0);
      chk("sum_held", 32'(sum8), 32'(held[7:0]));
      chk("cout_held", 32'(cout8), 32'(held[8]));
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("done_pulse", 32'(done8), 32'd1);
    chk("busy_done", 32'(busy8), 32'd0);
    chk("sum", 32'(sum8), 32'(es));
    chk("cout", 32'(cout8), 32'(ec));
    held = {ec, es};
  endtask

  task automatic idle8(input int n);
    start8 = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy8), 32'd0);
      chk("idle_done", 32'(done8), 32'd0);
      chk("idle_sum", 32'({cout8, sum8}), 32'(held));
    end
  endtask

  initial begin
    tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    rst = 1'b1;
    start8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5; cin8 = 1'b1;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_res1", 32'({cout1, sum1}), 32'd0);
    rst = 1'b0;
    start8 = 1'b0;
    idle8(2);

    // Back-to-back: each op accepted in the previous op's DONE cycle.
    for (int i = 0; i < 7; i++)
      run8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, 1'b0);
    idle8(2);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      logic [8:0] tot;
      int         gap;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom % 2);
      tot = {1'b0, ra} + {1'b0, rb} + 9'(rc);
      run8(ra, rb, rc, tot[7:0], tot[8], 1'($urandom % 2));
      gap = int'($urandom % 3);
      if (gap != 0) idle8(gap);
    end
    idle8(1);

    // Reset during the 4th RUN cycle aborts with no done pulse.
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_sum", 32'(sum8), 32'd0);
    chk("abort_cout", 32'(cout8), 32'd0);
    held = '0;
    idle8(10);
    run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    idle8(1);

    // Reset wins over a simultaneous start.
    start8 = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    chk("rst_prio_busy", 32'(busy8), 32'd0);
    held = '0;
    idle8(1);

    for (int v = 0; v < 8; v++) begin
      int e;
      a1 = 1'(v >> 2);
      b1 = 1'(v >> 1);
      cin1 = 1'(v);
      e = (v >> 2) % 2 + (v >> 1) % 2 + v % 2;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      a1 = ~a1;
      chk("w1_busy", 32'(busy1), 32'd1);
      chk("w1_done_early", 32'(done1), 32'd0);
      @(negedge clk);
      chk("w1_done", 32'(done1), 32'd1);
      chk("w1_res", 32'({cout1, sum1}), 32'(e));
      @(negedge clk);
      chk("w1_idle", 32'(done1 | busy1), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
